// File: rtl/svcs_trnx_arbiter.sv
// svcs_trnx_arbiter: round-robin arbiter framing a 4-word header plus payload per grant onto one stream; define SVCS_TRNX_TIMEOUT_EN for the payload stall timeout
module svcs_trnx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int MAX_PAYLOAD = 4096,
  parameter int LEN_W       = 13,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_type,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  output logic [N_REQ-1:0]          req_grant,
  output logic [N_REQ-1:0]          req_done,
  input  logic [N_REQ-1:0]          pld_valid,
  input  logic [N_REQ*DATA_W-1:0]   pld_data,
  output logic [N_REQ-1:0]          pld_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      err_len,
  output logic [DATA_W-1:0]         trnx_id
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [2:0] {IDLE, ARB, HDR, PLD, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, g, pick;
  logic found, bad, hs, pad, to_err, pv;
  logic [DATA_W-1:0] typ, pd, hdr;
  logic [LEN_W-1:0] len, cnt, lsel;
  logic [1:0] w;
  logic [N_REQ-1:0] oh;
  always_comb begin
    pick = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[IW'((int'(ptr) + k) % N_REQ)]) begin
        found = 1'b1;
        pick = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end
  assign lsel = req_len[pick*LEN_W +: LEN_W];
  assign bad = lsel == '0 || lsel > LEN_W'(MAX_PAYLOAD);
  assign oh = N_REQ'(1) << g;
  assign pv = pld_valid[g];
  assign pd = pld_data[g*DATA_W +: DATA_W];
  assign hdr = w == 2'd0 ? typ : w == 2'd1 ? trnx_id : w == 2'd2 ? DATA_W'(g) : DATA_W'(len);
  assign out_valid = state == HDR || (state == PLD && (pad || pv));
  assign out_data = state == HDR ? hdr : (state == PLD && !pad) ? pd : '0;
  assign out_last = state == PLD && out_valid && cnt == LEN_W'(1);
  assign hs = out_valid && out_ready;
  assign req_grant = (state == HDR || state == PLD) ? oh : '0;
  assign req_done = (state == DONE || state == ERR) ? oh : '0;
  assign pld_ready = (state == PLD && !pad && out_ready) ? oh : '0;
  assign busy = state != IDLE;
  assign err_len = state == ERR || to_err;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = |req_valid ? ARB : IDLE;
      ARB:  state_nx = !found ? IDLE : bad ? ERR : HDR;
      HDR:  state_nx = (hs && w == 2'd3) ? PLD : HDR;
      PLD:  state_nx = (hs && cnt == LEN_W'(1)) ? DONE : PLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      typ <= '0;
      len <= '0;
      cnt <= '0;
      w <= '0;
      trnx_id <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB && found) begin
        g <= pick;
        ptr <= (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
        typ <= req_type[pick*DATA_W +: DATA_W];
        len <= lsel;
      end
      if (state == HDR && hs) w <= w + 1'b1;
      if (state == HDR && hs && w == 2'd3) cnt <= len;
      if (state == PLD && hs) cnt <= cnt - 1'b1;
      if (state == DONE) trnx_id <= trnx_id + 1'b1;
    end
  end
`ifdef SVCS_TRNX_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall;
  logic pad_q, to_err_q;
  assign pad = pad_q;
  assign to_err = to_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall <= '0;
      pad_q <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= 1'b0;
      if (state != PLD) begin
        stall <= '0;
        pad_q <= 1'b0;
      end else if (!pad_q) begin
        if (pv) stall <= '0;
        else if (stall == SW'(TIMEOUT_CYC - 1)) begin
          pad_q <= 1'b1;
          to_err_q <= 1'b1;
        end else stall <= stall + 1'b1;
      end
    end
  end
`else
  assign pad = 1'b0;
  assign to_err = 1'b0;
`endif
endmodule
